// File: rtl/led_pkg.sv
// Shared types and constants for the binary-to-BCD LED scan driver.
package led_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    // Segments g..a for hex values 0..F, active-high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };

    // Decimal digits needed to represent 2^bin_w - 1 (exact for bin_w <= 64).
    function automatic int unsigned min_digits(input int unsigned bin_w);
        longint unsigned maxv;
        int unsigned     n;
        maxv = (bin_w >= 64) ? '1 : ((64'd1 << bin_w) - 64'd1);
        n    = 1;
        while (maxv >= 64'd10) begin
            maxv = maxv / 64'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Valid/ready front end and bit-serial double-dabble converter.
module bin2bcd_seq
    import led_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  bcd_valid
);

    localparam int unsigned ACC_W = DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    conv_state_t      state, state_nxt;
    logic [BIN_W-1:0] sr, sr_sh;
    logic [ACC_W-1:0] acc, acc_adj, acc_sh;
    logic [CNT_W-1:0] cnt;
    logic             last_shift;

    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        bcd_valid = (state == DONE);
    end

    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
        {acc_sh, sr_sh} = {acc_adj, sr} << 1;
    end

    // bcd_out is loaded on the final shift so it is already valid during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            bcd_out <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                sr  <= bin_in;
                acc <= '0;
                cnt <= CNT_W'(BIN_W);
            end else if (state == SHIFT) begin
                sr  <= sr_sh;
                acc <= acc_sh;
                cnt <= cnt - CNT_W'(1);
            end
            if (last_shift) bcd_out <= acc_sh;
        end
    end

endmodule

// File: rtl/bin2bcd_led_scan.sv
// Multi-digit 7-segment driver: BCD conversion, digit scanning, blanking, polarity.
module bin2bcd_led_scan
    import led_pkg::*;
#(
    parameter int unsigned BIN_W          = 16,
    parameter int unsigned DIGITS         = 5,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          BLANK_LZ       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig
);

    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (BIN_W < 1) begin : g_bad_width
            $error("bin2bcd_led_scan: BIN_W must be >= 1");
        end
        if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
            $error("bin2bcd_led_scan: DIGITS too small for BIN_W");
        end
        if (SCAN_DIV < 2) begin : g_bad_div
            $error("bin2bcd_led_scan: SCAN_DIV must be >= 2");
        end
    endgenerate

    logic [DIGITS*4-1:0] disp;
    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic [DIGITS-1:0]   zero_from;
    logic [7:0]          seg_raw;
    logic [DIGITS-1:0]   dig_raw;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid)
    );

    always_ff @(posedge clk) begin
        if (rst)            disp <= '0;
        else if (bcd_valid) disp <= bcd_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // zero_from[i]: nibbles i..DIGITS-1 of the display are all zero.
    always_comb begin
        logic        run;
        int unsigned i;
        zero_from = '0;
        run       = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            i            = DIGITS - 1 - j;
            run          = run && (disp[i*4 +: 4] == 4'd0);
            zero_from[i] = run;
        end
    end

    always_comb begin
        seg_raw = '0;
        dig_raw = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                dig_raw[k]   = 1'b1;
                seg_raw[7]   = dp_in[k];
                seg_raw[6:0] = (BLANK_LZ && (k != 0) && zero_from[k])
                             ? 7'h00 : SEG_TABLE[disp[k*4 +: 4]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= {8{SEG_ACTIVE_LOW}};
            dig <= {DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            seg <= seg_raw ^ {8{SEG_ACTIVE_LOW}};
            dig <= dig_raw ^ {DIGITS{DIG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_bin2bcd_led_scan.sv
// Self-checking bench: three DUT variants (blanking, no blanking, active-low) share stimulus.
module tb_bin2bcd_led_scan;

    localparam int unsigned DIGITS = 5;
    localparam int unsigned SDIV   = 4;

    localparam logic [6:0] SEG_REF [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bin_in = '0;
    logic        in_valid = 1'b0;
    logic [4:0]  dp_in = '0;

    logic        m_ready, n_ready, p_ready, m_valid, n_valid, p_valid;
    logic [19:0] m_bcd, n_bcd, p_bcd;
    logic [7:0]  m_seg, n_seg, p_seg;
    logic [4:0]  m_dig, n_dig, p_dig;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    bin2bcd_led_scan #(.BIN_W(16), .DIGITS(DIGITS), .SCAN_DIV(SDIV), .BLANK_LZ(1'b1),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_main (
        .clk(clk), .rst(rst), .bin_in(bin_in), .in_valid(in_valid), .in_ready(m_ready),
        .dp_in(dp_in), .bcd_out(m_bcd), .bcd_valid(m_valid), .seg(m_seg), .dig(m_dig));

    bin2bcd_led_scan #(.BIN_W(16), .DIGITS(DIGITS), .SCAN_DIV(SDIV), .BLANK_LZ(1'b0),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_noblank (
        .clk(clk), .rst(rst), .bin_in(bin_in), .in_valid(in_valid), .in_ready(n_ready),
        .dp_in(dp_in), .bcd_out(n_bcd), .bcd_valid(n_valid), .seg(n_seg), .dig(n_dig));

    bin2bcd_led_scan #(.BIN_W(16), .DIGITS(DIGITS), .SCAN_DIV(SDIV), .BLANK_LZ(1'b1),
                       .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_pol (
        .clk(clk), .rst(rst), .bin_in(bin_in), .in_valid(in_valid), .in_ready(p_ready),
        .dp_in(dp_in), .bcd_out(p_bcd), .bcd_valid(p_valid), .seg(p_seg), .dig(p_dig));

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int unsigned v, input logic [4:0] dp,
                                           input bit blank, input int unsigned idx);
        int unsigned nd, t, d;
        bit          show;
        nd = 1;
        t  = v / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        t = v;
        for (int unsigned i = 0; i < idx; i++) t = t / 10;
        d    = t % 10;
        show = !blank || (idx < nd);
        return {dp[idx], show ? SEG_REF[d] : 7'h00};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        dp_in = '0;
        repeat (3) @(negedge clk);
        n_cmp += 7;
        if (m_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_ready got %b want 1", m_ready); end
        if (m_bcd !== 20'h0)    begin n_bad++; $display("FAIL rst_bcd got %h want 00000", m_bcd); end
        if (m_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_valid got %b want 0", m_valid); end
        if (m_seg !== 8'h00)    begin n_bad++; $display("FAIL rst_seg got %h want 00", m_seg); end
        if (m_dig !== 5'h00)    begin n_bad++; $display("FAIL rst_dig got %b want 00000", m_dig); end
        if (p_seg !== 8'hff)    begin n_bad++; $display("FAIL rst_pol_seg got %h want ff", p_seg); end
        if (p_dig !== 5'h1f)    begin n_bad++; $display("FAIL rst_pol_dig got %b want 11111", p_dig); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp += 4;
        if (m_seg !== 8'h3f)    begin n_bad++; $display("FAIL post_rst_seg got %h want 3f", m_seg); end
        if (m_dig !== 5'h01)    begin n_bad++; $display("FAIL post_rst_dig got %b want 00001", m_dig); end
        if (p_seg !== 8'hc0)    begin n_bad++; $display("FAIL post_rst_pol_seg got %h want c0", p_seg); end
        if (p_dig !== 5'h1e)    begin n_bad++; $display("FAIL post_rst_pol_dig got %b want 11110", p_dig); end
    endtask

    // Transfer at the cycle of the driving negedge; result must pulse exactly 17 cycles later.
    task automatic test_convert(input int unsigned v);
        logic [19:0] want;
        want = to_bcd(v);
        @(negedge clk);
        n_cmp++;
        if (m_ready !== 1'b1) begin n_bad++; $display("FAIL conv_ready_pre got %b want 1", m_ready); end
        bin_in   = 16'(v);
        in_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                in_valid = 1'b0;
                bin_in   = 16'($urandom);
            end
            n_cmp++;
            if (m_valid !== (n == 17)) begin
                n_bad++;
                $display("FAIL conv_valid_t%0d v=%0d got %b want %b", n, v, m_valid, (n == 17));
            end
            if (n == 17) begin
                n_cmp++;
                if (m_bcd !== want) begin
                    n_bad++;
                    $display("FAIL conv_bcd v=%0d got %h want %h", v, m_bcd, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back(input int unsigned a, input int unsigned b);
        int          low, acc_at;
        int          res_t[$];
        logic [19:0] res_v[$];
        low    = 0;
        acc_at = -1;
        @(negedge clk);
        bin_in   = 16'(a);
        in_valid = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 1) bin_in = 16'(b);
            if (acc_at >= 0 && n == acc_at + 1) begin
                in_valid = 1'b0;
                bin_in   = 16'($urandom);
            end
            if (m_valid === 1'b1) begin
                res_t.push_back(n);
                res_v.push_back(m_bcd);
            end
            if (acc_at < 0) begin
                if (m_ready !== 1'b1) low++;
                else if (in_valid) acc_at = n;
            end
        end
        in_valid = 1'b0;
        n_cmp += 3;
        if (low !== 17)    begin n_bad++; $display("FAIL b2b_busy_cycles got %0d want 17", low); end
        if (acc_at !== 18) begin n_bad++; $display("FAIL b2b_accept_cycle got %0d want 18", acc_at); end
        if (res_t.size() !== 2) begin
            n_bad++;
            $display("FAIL b2b_result_count got %0d want 2", res_t.size());
        end else begin
            n_cmp += 4;
            if (res_t[0] !== 17)        begin n_bad++; $display("FAIL b2b_t0 got %0d want 17", res_t[0]); end
            if (res_v[0] !== to_bcd(a)) begin n_bad++; $display("FAIL b2b_v0 got %h want %h", res_v[0], to_bcd(a)); end
            if (res_t[1] !== 35)        begin n_bad++; $display("FAIL b2b_t1 got %0d want 35", res_t[1]); end
            if (res_v[1] !== to_bcd(b)) begin n_bad++; $display("FAIL b2b_v1 got %h want %h", res_v[1], to_bcd(b)); end
        end
    endtask

    task automatic test_mid_reset();
        int pulses;
        pulses = 0;
        @(negedge clk);
        bin_in   = 16'd40000;
        in_valid = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (m_valid !== 1'b0) pulses++;
        end
        n_cmp += 3;
        if (pulses !== 0)       begin n_bad++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
        if (m_bcd !== 20'h0)    begin n_bad++; $display("FAIL midrst_bcd got %h want 00000", m_bcd); end
        if (m_ready !== 1'b1)   begin n_bad++; $display("FAIL midrst_ready got %b want 1", m_ready); end
    endtask

    // Reset first so the scan phase is known from the cycle count since release.
    task automatic test_scan(input int unsigned v, input logic [4:0] dp);
        bit          seen;
        int unsigned idx;
        logic [4:0]  w_dig;
        logic [7:0]  w_m, w_n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        dp_in = dp;
        @(negedge clk);
        bin_in   = 16'(v);
        in_valid = 1'b1;
        seen     = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (m_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL scan_conv_timeout v=%0d got none want bcd_valid", v); end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 40; s++) begin
            @(negedge clk);
            idx   = ((cyc - 1) / SDIV) % DIGITS;
            w_dig = 5'(1 << idx);
            w_m   = exp_seg(v, dp, 1'b1, idx);
            w_n   = exp_seg(v, dp, 1'b0, idx);
            n_cmp += 5;
            if (m_dig !== w_dig)  begin n_bad++; $display("FAIL scan_dig v=%0d c=%0d got %b want %b", v, cyc, m_dig, w_dig); end
            if (m_seg !== w_m)    begin n_bad++; $display("FAIL scan_seg v=%0d d=%0d got %h want %h", v, idx, m_seg, w_m); end
            if (n_seg !== w_n)    begin n_bad++; $display("FAIL scan_noblank_seg v=%0d d=%0d got %h want %h", v, idx, n_seg, w_n); end
            if (p_seg !== ~w_m)   begin n_bad++; $display("FAIL scan_pol_seg v=%0d d=%0d got %h want %h", v, idx, p_seg, ~w_m); end
            if (p_dig !== ~w_dig) begin n_bad++; $display("FAIL scan_pol_dig v=%0d c=%0d got %b want %b", v, cyc, p_dig, ~w_dig); end
        end
        dp_in = '0;
    endtask

    initial begin
        test_reset();
        test_convert(65535);
        test_convert(0);
        test_convert(1);
        test_convert(10000);
        for (int i = 0; i < 6; i++) test_convert($urandom_range(0, 65535));
        test_back_to_back(12345, 999);
        for (int i = 0; i < 3; i++) test_back_to_back($urandom_range(0, 65535), $urandom_range(0, 65535));
        test_mid_reset();
        test_scan(7, 5'b00100);
        test_scan(1, 5'b00000);
        test_scan(0, 5'b11111);
        test_scan(10000, 5'b00001);
        test_scan(65535, 5'b01010);
        for (int i = 0; i < 3; i++) test_scan($urandom_range(0, 65535), 5'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_led_scan.md
Name: bin2bcd_led_scan

Overview:
Parametrised multi-digit 7-segment display driver. It accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock. It then time-multiplexes the digits onto a shared segment bus, with leading-zero blanking, per-digit decimal points and selectable output polarity. It sits between application logic and the board's LED pins.

Parameters:
BIN_W, 16, binary input width; must be >= 1.
DIGITS, 5, number of display digits; elaboration error unless 10^DIGITS > 2^BIN_W - 1.
SCAN_DIV, 50000, clocks per digit during scanning; must be >= 2.
BLANK_LZ, 1, 1 = blank leading zeros (digit 0 always shown).
SEG_ACTIVE_LOW, 0, 1 = invert seg outputs.
DIG_ACTIVE_LOW, 0, 1 = invert dig outputs.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
bin_in  input  BIN_W  binary value to convert.
in_valid  input  1  bin_in valid.
in_ready  output  1  converter idle; a transfer occurs when in_valid && in_ready.
dp_in  input  DIGITS  decimal point per digit, bit i = digit i (i = 0 is least significant); sampled live, never blanked.
bcd_out  output  DIGITS*4  last converted result; nibble i = digit i.
bcd_valid  output  1  one-cycle pulse when bcd_out updates.
seg  output  8  bits [6:0] = segments g..a, bit 7 = dp; active-high before the polarity option.
dig  output  DIGITS  one-hot digit enable; active-high before the polarity option.

Behaviour:
- Reset values: in_ready=1, bcd_out=0, bcd_valid=0, display register=0, prescaler=0, scan index=0. seg and dig are all-inactive (polarity applied).
- Converter FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On a transfer, load the shift register with bin_in, clear the BCD accumulator and set the bit counter to BIN_W; go to SHIFT.
- SHIFT: in_ready=0. Each clock, add 3 to every accumulator nibble >= 5, then shift the {accumulator, shift register} pair left by 1 and decrement the bit counter. After BIN_W shift clocks, go to DONE.
- DONE: bcd_out and the display register take the accumulator value; bcd_valid=1 for this cycle only; go to IDLE.
- Latency: transfer on cycle T, then bcd_valid and the new bcd_out on cycle T+BIN_W+1. Minimum spacing between transfers is BIN_W+2 cycles.
- in_valid while busy is ignored, with no queuing. bin_in is sampled only at the transfer.
- Scan prescaler: counts 0..SCAN_DIV-1 and wraps. At the terminal count, the scan index increments modulo DIGITS (DIGITS-1 wraps to 0).
- Output stage: seg and dig are registered together, one cycle after the index/display state, so they always refer to the same digit.
- First clock after reset release: the output stage loads digit 0 with value '0', i.e. seg=0x3f and dig=one-hot bit 0.
- Blanking: digit i (i > 0) shows segments 0x00 when BLANK_LZ=1 and nibbles i..DIGITS-1 are all zero. dp still follows dp_in[i].
- Segment map for 0..F: 3f 06 5b 4f 66 6d 7d 07 7f 6f 77 7c 39 5e 79 71.
- Display update: the display register changes only in DONE. The scan never shows partial conversion results.
- Reset during SHIFT/DONE: conversion is aborted, there is no bcd_valid pulse, and all reset values apply.
- Polarity options invert the final registered outputs only.

Decomposition:
- Package led_pkg: the 16-entry segment constant table, the converter state enum (IDLE/SHIFT/DONE), and a function giving the minimum digit count for a given BIN_W, used by the elaboration check.
- Sub-module bin2bcd_seq: the handshake plus double-dabble FSM, parametrised by BIN_W and DIGITS.
- The top level holds the display register, prescaler, scan index, blanking logic and output stage.

Test Plan:
- Reset: hold rst 3 cycles -> in_ready=1, bcd_out=0, seg=0x00, dig=0. Cycle after release -> seg=0x3f, dig=5'b00001.
- Conversion: bin_in=65535 with in_valid pulsed at T -> bcd_valid high only at T+17, bcd_out=20'h65535. Also bin_in=0 -> 20'h00000.
- Busy handshake: 12345 accepted, then bin_in=999 with in_valid held high -> in_ready=0 for 17 cycles. 999 is accepted the cycle in_ready returns to 1. Results are 20'h12345, then 20'h00999 (17 cycles after the second transfer).
- Scan and blank: SCAN_DIV=4, value 7, dp_in=5'b00100 -> dig steps 00001..10000 every 4 cycles and wraps after 20. Segments per digit: digit0 seg=0x07, digit2 seg=0x80, others 0x00. With BLANK_LZ=0, digits 1..4 show 0x3f, and digit2 shows 0xbf.
- Reset mid-conversion: assert rst on the 8th SHIFT cycle of 40000 -> no bcd_valid, bcd_out=0, in_ready=1 after release.
- Polarity: SEG_ACTIVE_LOW=1 and DIG_ACTIVE_LOW=1 with value 1 -> digit0 shows seg=0xf9, dig=5'b11110.
